// File: rtl/pipeline_hazard_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : pipeline_hazard_ctrl_pkg
// Brief    : Opcodes, FSM state encoding and control-vector types for the
//            pipeline hazard controller.
// Revision : 1.0
// ============================================================================
package pipeline_hazard_ctrl_pkg;

    localparam int REG_ADDR_WIDTH = 5;

    localparam logic [6:0] OPCODE_LOAD  = 7'b0000011;
    localparam logic [6:0] OPCODE_STORE = 7'b0100011;

    typedef enum logic [1:0] {
        HZ_RUN      = 2'd0,
        HZ_MEM_WAIT = 2'd1,
        HZ_ERROR    = 2'd2
    } hz_state_e;

    typedef struct packed {
        logic pc_en;
        logic if_id_en;
        logic id_ex_en;
        logic ex_mem_en;
        logic if_id_flush;
        logic id_ex_flush;
        logic mem_wb_bubble;
    } pipe_ctrl_t;

    localparam pipe_ctrl_t CTRL_NORMAL = '{
        pc_en: 1'b1, if_id_en: 1'b1, id_ex_en: 1'b1, ex_mem_en: 1'b1,
        if_id_flush: 1'b0, id_ex_flush: 1'b0, mem_wb_bubble: 1'b0
    };

    localparam pipe_ctrl_t CTRL_FREEZE = '{
        pc_en: 1'b0, if_id_en: 1'b0, id_ex_en: 1'b0, ex_mem_en: 1'b0,
        if_id_flush: 1'b0, id_ex_flush: 1'b0, mem_wb_bubble: 1'b1
    };

    localparam pipe_ctrl_t CTRL_BRANCH = '{
        pc_en: 1'b1, if_id_en: 1'b1, id_ex_en: 1'b1, ex_mem_en: 1'b1,
        if_id_flush: 1'b1, id_ex_flush: 1'b1, mem_wb_bubble: 1'b0
    };

    // Hold PC and IF/ID, push one bubble into EX while older instructions drain.
    localparam pipe_ctrl_t CTRL_LOAD_USE = '{
        pc_en: 1'b0, if_id_en: 1'b0, id_ex_en: 1'b1, ex_mem_en: 1'b1,
        if_id_flush: 1'b0, id_ex_flush: 1'b1, mem_wb_bubble: 1'b0
    };

    function automatic logic is_mem_op(input logic [6:0] opcode);
        return (opcode == OPCODE_LOAD) || (opcode == OPCODE_STORE);
    endfunction

endpackage
`default_nettype wire

// File: rtl/pipeline_hazard_ctrl_sat_counter.sv
`default_nettype none
// ============================================================================
// Module   : sat_counter
// Brief    : Up-counter that sticks at its all-ones value.
// Revision : 1.0
// ============================================================================
module sat_counter #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (inc && (count_q != {WIDTH{1'b1}})) begin
            count_d = count_q + WIDTH'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule
`default_nettype wire

// File: rtl/pipeline_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : pipeline_hazard_ctrl
// Brief    : Stall/flush sequencer for the 5-stage pipeline with data-memory
//            wait FSM, timeout error and saturating performance counters.
// Revision : 1.0
// ============================================================================
module pipeline_hazard_ctrl #(
    parameter int REG_ADDR_WIDTH = pipeline_hazard_ctrl_pkg::REG_ADDR_WIDTH,
    parameter int MEM_TIMEOUT    = 64,
    parameter int CNT_WIDTH      = 16
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic [REG_ADDR_WIDTH-1:0] IF_ID_rs1,
    input  logic [REG_ADDR_WIDTH-1:0] IF_ID_rs2,
    input  logic [6:0]                ID_EX_inst_opcode,
    input  logic [REG_ADDR_WIDTH-1:0] ID_EX_rd,
    input  logic [6:0]                EX_MEM_inst_opcode,
    input  logic                      branch_taken,
    input  logic                      dmem_ready,
    output logic                      dmem_req,
    output logic                      dmem_we,
    output logic                      pc_en,
    output logic                      IF_ID_en,
    output logic                      ID_EX_en,
    output logic                      EX_MEM_en,
    output logic                      IF_ID_flush,
    output logic                      ID_EX_flush,
    output logic                      MEM_WB_bubble,
    output logic                      mem_err,
    output logic [CNT_WIDTH-1:0]      stall_cnt,
    output logic [CNT_WIDTH-1:0]      flush_cnt
);

    import pipeline_hazard_ctrl_pkg::*;

    localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);

    hz_state_e         state_q;
    hz_state_e         state_d;
    logic [WAIT_W-1:0] wait_cnt_q;
    logic [WAIT_W-1:0] wait_cnt_d;

    logic       mem_op;
    logic       is_store;
    logic       freeze;
    logic       req_raw;
    logic       load_use;
    logic       branch_go;
    pipe_ctrl_t ctrl;

    assign mem_op   = is_mem_op(EX_MEM_inst_opcode);
    assign is_store = (EX_MEM_inst_opcode == OPCODE_STORE);

    assign load_use = (ID_EX_inst_opcode == OPCODE_LOAD) &&
                      (ID_EX_rd != '0) &&
                      ((ID_EX_rd == IF_ID_rs1) || (ID_EX_rd == IF_ID_rs2));

    always_comb begin
        req_raw = 1'b0;
        freeze  = 1'b0;
        case (state_q)
            HZ_RUN: begin
                req_raw = mem_op;
                freeze  = mem_op && !dmem_ready;
            end
            HZ_MEM_WAIT: begin
                req_raw = 1'b1;
                freeze  = !dmem_ready;
            end
            default: begin
                req_raw = 1'b0;
                freeze  = 1'b1;
            end
        endcase
    end

    // A branch seen while frozen stays in EX and is acted on at release.
    assign branch_go = !freeze && branch_taken;

    always_comb begin
        ctrl = CTRL_NORMAL;
        if (freeze) begin
            ctrl = CTRL_FREEZE;
        end else if (branch_taken) begin
            ctrl = CTRL_BRANCH;
        end else if (load_use) begin
            ctrl = CTRL_LOAD_USE;
        end
    end

    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        case (state_q)
            HZ_RUN: begin
                if (mem_op && !dmem_ready) begin
                    state_d    = HZ_MEM_WAIT;
                    wait_cnt_d = WAIT_W'(1);
                end
            end
            HZ_MEM_WAIT: begin
                if (dmem_ready) begin
                    state_d    = HZ_RUN;
                    wait_cnt_d = '0;
                end else if (wait_cnt_q == WAIT_W'(MEM_TIMEOUT)) begin
                    state_d = HZ_ERROR;
                end else begin
                    wait_cnt_d = wait_cnt_q + WAIT_W'(1);
                end
            end
            default: begin
                state_d = HZ_ERROR;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= HZ_RUN;
            wait_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
        end
    end

    // Reset forces every pipeline control and the memory request low at once.
    assign dmem_req      = reset_n && req_raw;
    assign dmem_we       = reset_n && req_raw && is_store;
    assign pc_en         = reset_n && ctrl.pc_en;
    assign IF_ID_en      = reset_n && ctrl.if_id_en;
    assign ID_EX_en      = reset_n && ctrl.id_ex_en;
    assign EX_MEM_en     = reset_n && ctrl.ex_mem_en;
    assign IF_ID_flush   = reset_n && ctrl.if_id_flush;
    assign ID_EX_flush   = reset_n && ctrl.id_ex_flush;
    assign MEM_WB_bubble = reset_n && ctrl.mem_wb_bubble;
    assign mem_err       = (state_q == HZ_ERROR);

    sat_counter #(
        .WIDTH (CNT_WIDTH)
    ) u_stall_cnt (
        .clk     (clk),
        .reset_n (reset_n),
        .inc     (!ctrl.pc_en),
        .count   (stall_cnt)
    );

    sat_counter #(
        .WIDTH (CNT_WIDTH)
    ) u_flush_cnt (
        .clk     (clk),
        .reset_n (reset_n),
        .inc     (branch_go),
        .count   (flush_cnt)
    );

endmodule
`default_nettype wire
